// File: rtl/mem_io_pkg.sv
// Shared constants and types for the core-to-memory/IO bridge.
// Register offsets are relative to IO_BASE within the 16-word IO window.
package mem_io_pkg;

    localparam logic [23:0] IO_BASE = 24'hFFFFF0;

    localparam logic [3:0] OFF_LED      = 4'h0;
    localparam logic [3:0] OFF_SW       = 4'h1;
    localparam logic [3:0] OFF_TX       = 4'h2;
    localparam logic [3:0] OFF_STATUS   = 4'h3;
    localparam logic [3:0] OFF_TIMER_LO = 4'h4;
    localparam logic [3:0] OFF_TIMER_HI = 4'h5;

    typedef enum logic [1:0] {SEL_RAM, SEL_IO, SEL_NONE} sel_e;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_UNMAPPED = 3;

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// Synchronous byte FIFO feeding the serializer; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         accept_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         pop_ok, push_ok;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok   = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_i && (!full_o || pop_ok);
    assign accept_o = push_ok;
    assign data_o   = mem_q[rd_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PTR_ONE;
            if (pop_ok)  rd_q <= rd_q + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; equal pointers already mark it empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes the core bus into block RAM, a small IO register file and a TX FIFO,
// returning read data one cycle after the address.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [23:0]       core_to_mem_address,
    input  logic [15:0]       core_to_mem_data,
    input  logic              core_to_mem_write_enable,
    output logic [15:0]       mem_to_core_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata,
    input  logic [15:0]       switches,
    output logic [15:0]       leds,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    sel_e        sel_d, sel_q;
    logic [15:0] io_rdata_d, io_rdata_q;
    logic [15:0] leds_d, leds_q;
    logic [31:0] timer_q;
    logic [15:0] hold_d, hold_q;
    logic        overflow_d, overflow_q, unmapped_d, unmapped_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [15:0] status;
    logic [3:0]  offset;
    logic        io_wr, io_rd, st_wr, push, pop, accept, fifo_full, fifo_empty;

    assign offset = core_to_mem_address[3:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_d = SEL_NONE;
        if (core_to_mem_address[23:RAM_AW] == '0)
            sel_d = SEL_RAM;
        else if (core_to_mem_address[23:4] == IO_BASE[23:4])
            sel_d = SEL_IO;
    end

    assign ram_addr  = core_to_mem_address[RAM_AW-1:0];
    assign ram_wdata = core_to_mem_data;
    assign ram_we    = core_to_mem_write_enable && (sel_d == SEL_RAM);

    assign io_wr = core_to_mem_write_enable && (sel_d == SEL_IO);
    assign io_rd = !core_to_mem_write_enable && (sel_d == SEL_IO);
    assign st_wr = io_wr && (offset == OFF_STATUS);
    assign push  = io_wr && (offset == OFF_TX);
    assign pop   = tx_valid && tx_ready;

    always_comb begin
        status              = '0;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_FULL]     = fifo_full;
        status[ST_OVERFLOW] = overflow_q;
        status[ST_UNMAPPED] = unmapped_q;
    end

    always_comb begin
        io_rdata_d = '0;
        case (offset)
            OFF_LED:      io_rdata_d = leds_q;
            OFF_SW:       io_rdata_d = sw_sync_q;
            OFF_STATUS:   io_rdata_d = status;
            OFF_TIMER_LO: io_rdata_d = timer_q[15:0];
            OFF_TIMER_HI: io_rdata_d = hold_q;
            default:      io_rdata_d = '0;
        endcase
    end

    // Sticky flags: the W1C clear is applied first so a same-cycle set wins.
    assign overflow_d = (overflow_q && !(st_wr && core_to_mem_data[ST_OVERFLOW]))
                      || (push && !accept);
    assign unmapped_d = (unmapped_q && !(st_wr && core_to_mem_data[ST_UNMAPPED]))
                      || ((sel_d == SEL_NONE)
                          && (core_to_mem_write_enable || core_to_mem_address != '0));
    assign leds_d = (io_wr && offset == OFF_LED) ? core_to_mem_data : leds_q;
    assign hold_d = (io_rd && offset == OFF_TIMER_LO) ? timer_q[31:16] : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= SEL_NONE;
            io_rdata_q <= '0;
            leds_q     <= '0;
            timer_q    <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
            unmapped_q <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            sel_q      <= sel_d;
            io_rdata_q <= io_rdata_d;
            leds_q     <= leds_d;
            timer_q    <= timer_q + 32'd1;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            unmapped_q <= unmapped_d;
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
        end
    end

    always_comb begin
        mem_to_core_data = '0;
        case (sel_q)
            SEL_RAM: mem_to_core_data = ram_rdata;
            SEL_IO:  mem_to_core_data = io_rdata_q;
            default: mem_to_core_data = '0;
        endcase
    end

    assign leds     = leds_q;
    assign tx_valid = !fifo_empty;

    tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .data_i   (core_to_mem_data[7:0]),
        .pop_i    (pop),
        .data_o   (tx_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .accept_o (accept)
    );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: a block-RAM stand-in, a queue-based reference model
// compared every cycle, and directed scenarios with hand-computed values.
module tb_mem_io_bridge;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] data = '0;
    logic        we = 1'b0;
    logic [15:0] mem_to_core_data;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] switches = '0;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_io_bridge #(.RAM_AW(14), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .core_to_mem_address      (addr),
        .core_to_mem_data         (data),
        .core_to_mem_write_enable (we),
        .mem_to_core_data         (mem_to_core_data),
        .ram_addr                 (ram_addr),
        .ram_wdata                (ram_wdata),
        .ram_we                   (ram_we),
        .ram_rdata                (ram_rdata),
        .switches                 (switches),
        .leds                     (leds),
        .tx_data                  (tx_data),
        .tx_valid                 (tx_valid),
        .tx_ready                 (tx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Block RAM stand-in: one-cycle registered read, read-before-write.
    logic [15:0] ram_mem [16384] = '{default: 16'h0};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // 0 = RAM, 1 = IO window, 2 = unmapped
    function automatic int region(input logic [23:0] a);
        if (a < 24'h004000) return 0;
        if (a >= 24'hFFFFF0) return 1;
        return 2;
    endfunction

    // Reference model, advanced once per rising edge.
    logic [7:0]  m_q[$];
    logic [15:0] m_leds = '0, m_hold = '0, sw_d1 = '0, sw_d2 = '0, exp_rd = '0;
    logic [31:0] m_timer = '0;
    logic        m_ovf = 1'b0, m_unm = 1'b0, m_pop, m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_leds = '0; m_hold = '0; m_timer = '0; m_ovf = 1'b0; m_unm = 1'b0;
            sw_d1 = '0; sw_d2 = '0; exp_rd = '0;
        end else begin
            m_pop  = (m_q.size() != 0) && tx_ready;
            m_full = (m_q.size() == FIFO_DEPTH);
            exp_rd = 16'h0;
            if (region(addr) == 0) exp_rd = ram_mem[addr[13:0]];
            else if (region(addr) == 1) begin
                case (addr[3:0])
                    4'h0: exp_rd = m_leds;
                    4'h1: exp_rd = sw_d2;
                    4'h3: exp_rd = {12'h0, m_unm, m_ovf, m_full, m_q.size() == 0};
                    4'h4: exp_rd = m_timer[15:0];
                    4'h5: exp_rd = m_hold;
                    default: exp_rd = 16'h0;
                endcase
            end
            if (m_pop) void'(m_q.pop_front());
            if (region(addr) == 1 && we) begin
                if (addr[3:0] == 4'h0) m_leds = data;
                if (addr[3:0] == 4'h3) begin
                    if (data[2]) m_ovf = 1'b0;
                    if (data[3]) m_unm = 1'b0;
                end
                if (addr[3:0] == 4'h2) begin
                    if (!m_full || m_pop) m_q.push_back(data[7:0]);
                    else m_ovf = 1'b1;
                end
            end
            if (region(addr) == 1 && !we && addr[3:0] == 4'h4) m_hold = m_timer[31:16];
            if (region(addr) == 2 && (we || addr != 24'h0)) m_unm = 1'b1;
            m_timer = m_timer + 32'd1;
            sw_d2 = sw_d1;
            sw_d1 = switches;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("rdata", {16'h0, mem_to_core_data}, {16'h0, exp_rd});
            check("leds", {16'h0, leds}, {16'h0, m_leds});
            check("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
            if (m_q.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
            check("ram_we", {31'h0, ram_we}, {31'h0, we && region(addr) == 0});
            if (region(addr) == 0) begin
                check("ram_addr", {18'h0, ram_addr}, {18'h0, addr[13:0]});
                check("ram_wdata", {16'h0, ram_wdata}, {16'h0, data});
            end
        end
    end

    // One bus op starting just after a rising edge; the next cycle idles at 0.
    task automatic bus(input logic [23:0] a, input logic [15:0] d, input logic w,
                       output logic [15:0] rd, output logic we_in, output logic we_after);
        addr = a; data = d; we = w;
        @(negedge clk); we_in = ram_we;
        @(posedge clk); #1;
        addr = '0; data = '0; we = 1'b0;
        @(negedge clk); rd = mem_to_core_data; we_after = ram_we;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        logic [15:0] r; logic x, y;
        bus(a, d, 1'b1, r, x, y);
    endtask

    task automatic rd(input logic [23:0] a, output logic [15:0] v);
        logic x, y;
        bus(a, 16'h0, 1'b0, v, x, y);
    endtask

    initial begin
        logic [15:0] v;
        logic        w_in, w_after;
        logic [7:0]  got[$];
        int          guard;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_rdata", {16'h0, mem_to_core_data}, 32'h0);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);

        bus(24'h003C8C, 16'h1234, 1'b1, v, w_in, w_after);
        check("ram_we_pulse", {31'h0, w_in}, 32'h1);
        check("ram_we_after", {31'h0, w_after}, 32'h0);
        rd(24'h003C8C, v);
        check("ram_readback", {16'h0, v}, 32'h1234);
        wr(24'h003FFF, 16'hBEEF);
        rd(24'h003FFF, v);
        check("ram_top_word", {16'h0, v}, 32'hBEEF);

        bus(24'hFFFFF0, 16'h00A5, 1'b1, v, w_in, w_after);
        check("leds_after_write", {16'h0, leds}, 32'h00A5);
        check("led_write_no_ram_we", {31'h0, w_in}, 32'h0);
        rd(24'hFFFFF0, v);
        check("led_readback", {16'h0, v}, 32'h00A5);

        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(24'hFFFFF2, 16'h0041 + 16'(i));
        rd(24'hFFFFF3, v);
        check("status_full_ovf", {16'h0, v}, 32'h0006);
        check("tx_head", {24'h0, tx_data}, 32'h41);
        rd(24'hFFFFF2, v);
        check("tx_read_zero", {16'h0, v}, 32'h0);

        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid) got.push_back(tx_data);
        end
        @(posedge clk); #1;
        check("drain_count", got.size(), 4);
        for (int k = 0; k < 4; k++)
            check("drain_byte", {24'h0, (k < got.size()) ? got[k] : 8'hEE}, 32'h41 + k);
        rd(24'hFFFFF3, v);
        check("status_empty_ovf", {16'h0, v}, 32'h0005);
        wr(24'hFFFFF3, 16'h0004);
        rd(24'hFFFFF3, v);
        check("status_w1c", {16'h0, v}, 32'h0001);

        switches = 16'hC3A7;
        repeat (3) @(posedge clk);
        #1;
        rd(24'hFFFFF1, v);
        check("switch_read", {16'h0, v}, 32'hC3A7);
        wr(24'hFFFFF7, 16'hFFFF);
        rd(24'hFFFFF7, v);
        check("reserved_read", {16'h0, v}, 32'h0);

        bus(24'h800000, 16'h5555, 1'b1, v, w_in, w_after);
        check("unmapped_rdata", {16'h0, v}, 32'h0);
        check("unmapped_no_ram_we", {31'h0, w_in}, 32'h0);
        rd(24'hFFFFF3, v);
        check("status_unmapped", {16'h0, v}, 32'h0009);

        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(24'hFFFFF2, 16'h0051 + 16'(i));
        tx_ready = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset_drops_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_clears_leds", {16'h0, leds}, 32'h0);
        check("reset_clears_rdata", {16'h0, mem_to_core_data}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rd(24'hFFFFF3, v);
        check("status_after_reset", {16'h0, v}, 32'h0001);

        guard = 0;
        while (m_timer != 32'h0000FFFF && guard < 70000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("timer_reached", {31'h0, guard < 70000}, 32'h1);
        rd(24'hFFFFF4, v);
        check("timer_lo", {16'h0, v}, 32'hFFFF);
        rd(24'hFFFFF5, v);
        check("timer_hi_hold", {16'h0, v}, 32'h0000);
        rd(24'hFFFFF4, v);
        check("timer_lo_next", {16'h0, v}, 32'h0003);
        rd(24'hFFFFF5, v);
        check("timer_hi_next", {16'h0, v}, 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
